// File: rtl/rsnn_ser_pkg.sv
// ----------------------------------------------------------------------------
// rsnn_ser_pkg
//
// Shared definitions for the RSNN serial parameter-load transmitter:
//   - ser_state_e : controller states (IDLE, WAIT_WORD, SHIFT, WAIT_ACK,
//                   FINISH, ERROR)
//   - DEF_*       : default word width, image length and ack timeout
//   - cnt_w()     : counter width helper built on $clog2, never below 1 bit
//
// Optional build macro used by the importing files: RSNN_PARAM_PARITY_EN
// ----------------------------------------------------------------------------
package rsnn_ser_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_WORD,
      SHIFT,
      WAIT_ACK,
      FINISH,
      ERROR
   } ser_state_e;

   localparam int DEF_WORD_W      = 8;
   localparam int DEF_NUM_WORDS   = 24;
   localparam int DEF_ACK_TIMEOUT = 16;

   // Width of a counter that must hold the values 0 .. n-1.
   // A one-value counter still needs a physical bit.
   function automatic int cnt_w(input int n);
      cnt_w = (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : rsnn_ser_pkg

// File: rtl/rsnn_piso_shreg.sv
// ----------------------------------------------------------------------------
// rsnn_piso_shreg
//
// Loadable MSB-first parallel-in / serial-out shift register with a bit
// counter and a last-bit flag. The serial output is taken straight from the
// MSB flop, so it is a registered signal. Zeros are shifted in from the
// bottom, so once every bit has been shifted out the output rests at 0.
//
// Build option: RSNN_PARAM_PARITY_EN
//   defined   - one even-parity bit (XOR of the word) is appended after the
//               word, giving WORD_W+1 serial bits per load
//   undefined - exactly WORD_W serial bits per load, no parity logic
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   load     in   capture word and restart the bit counter
//   shift    in   present the next bit on the following cycle
//   word     in   [WORD_W-1:0] parallel word to serialize
//   bit_out  out  current serial bit (MSB of the register)
//   last     out  the bit currently on bit_out is the final bit of the word
// ----------------------------------------------------------------------------
module rsnn_piso_shreg
   import rsnn_ser_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] word,
   output logic              bit_out,
   output logic              last
);

`ifdef RSNN_PARAM_PARITY_EN
   localparam int NBITS = WORD_W + 1;
`else
   localparam int NBITS = WORD_W;
`endif

   // The counter must be able to hold NBITS itself (all bits shifted out).
   localparam int                BIT_W    = cnt_w(NBITS + 1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(NBITS - 1);
   localparam logic [BIT_W-1:0]  BIT_END  = BIT_W'(NBITS);

   logic [NBITS-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path can leave it unassigned and no latch is inferred.
   always_comb begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      if (load) begin
`ifdef RSNN_PARAM_PARITY_EN
         shreg_d = {word, ^word};
`else
         shreg_d = word;
`endif
         bit_cnt_d = '0;
      end else if (shift) begin
         shreg_d = shreg_q << 1;
         // Saturate at the end-of-word value instead of wrapping.
         if (bit_cnt_q != BIT_END) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end
   end

   // NOTE: reset is synchronous and sampled inside the clocked block; state
   // is updated with non-blocking assignments so every flop sees the values
   // from before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign bit_out = shreg_q[NBITS-1];
   assign last    = (bit_cnt_q == BIT_LAST);

endmodule : rsnn_piso_shreg

// File: rtl/rsnn_param_serializer.sv
// ----------------------------------------------------------------------------
// rsnn_param_serializer
//
// Host-side transmitter for the RSNN serial parameter-load interface. A
// start request begins a full image of NUM_WORDS words. Each word is taken
// from the source through a valid/ready handshake, shifted MSB-first onto
// param_data while load_params frames it, and then acknowledged by the RSNN
// with a data_written pulse. After the last word the RSNN must raise
// end_writing. Any missing acknowledge within ACK_TIMEOUT cycles parks the
// block in a sticky error state until the next start or reset.
//
// Build option: RSNN_PARAM_PARITY_EN (even-parity bit appended per word,
// handled entirely inside rsnn_piso_shreg; the controller is unchanged).
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   start         in   one-cycle request to send a full image (ignored busy)
//   word_data     in   [WORD_W-1:0] parallel parameter word
//   word_valid    in   word_data is valid; must be held until accepted
//   word_ready    out  word accepted this cycle when word_valid is high
//   param_data    out  serial bit to RSNN data_in
//   load_params   out  high while the bits of a word are on param_data
//   data_written  in   RSNN per-word acknowledge pulse
//   end_writing   in   RSNN image-complete level
//   busy          out  transfer in progress
//   done          out  one-cycle pulse on successful completion
//   error         out  sticky acknowledge-timeout flag
// ----------------------------------------------------------------------------
module rsnn_param_serializer
   import rsnn_ser_pkg::*;
#(
   parameter int WORD_W      = DEF_WORD_W,
   parameter int NUM_WORDS   = DEF_NUM_WORDS,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              param_data,
   output logic              load_params,
   input  logic              data_written,
   input  logic              end_writing,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int                WCNT_W    = cnt_w(NUM_WORDS);
   localparam int                TMO_W     = cnt_w(ACK_TIMEOUT);
   localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NUM_WORDS - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);

   ser_state_e        state_q, state_d;
   logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic              word_ready_q, word_ready_d;
   logic              load_params_q, load_params_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic              sh_load;
   logic              sh_shift;
   logic              sh_last;
   logic              sh_bit;
   logic [TMO_W-1:0]  tmo_next;

   rsnn_piso_shreg #(
      .WORD_W (WORD_W)
   ) u_piso (
      .clk     (clk),
      .reset   (reset),
      .load    (sh_load),
      .shift   (sh_shift),
      .word    (word_data),
      .bit_out (sh_bit),
      .last    (sh_last)
   );

   // Timeout counter step, holding at its terminal value.
   assign tmo_next = (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      sh_load    = 1'b0;
      sh_shift   = 1'b0;

      case (state_q)
         IDLE, ERROR: begin
            if (start) begin
               state_d    = WAIT_WORD;
               word_cnt_d = '0;
            end
         end

         WAIT_WORD: begin
            // word_ready_q is high exactly while in this state.
            if (word_valid && word_ready_q) begin
               sh_load = 1'b1;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            sh_shift = 1'b1;
            if (sh_last) begin
               state_d   = WAIT_ACK;
               tmo_cnt_d = '0;
            end
         end

         WAIT_ACK: begin
            tmo_cnt_d = tmo_next;
            // The acknowledge is checked first so it wins over a
            // coincident timeout.
            if (data_written) begin
               if (word_cnt_q == WORD_LAST) begin
                  state_d   = FINISH;
                  tmo_cnt_d = '0;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
                  state_d    = WAIT_WORD;
               end
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d = ERROR;
            end
         end

         FINISH: begin
            tmo_cnt_d = tmo_next;
            // end_writing is a level, so it may already be high on entry.
            if (end_writing) begin
               state_d = IDLE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d = ERROR;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so that the registered
      // copies line up with the state they describe.
      word_ready_d  = (state_d == WAIT_WORD);
      load_params_d = (state_d == SHIFT);
      busy_d        = (state_d inside {WAIT_WORD, SHIFT, WAIT_ACK, FINISH});
      done_d        = (state_q == FINISH) && (state_d == IDLE);
      error_d       = (state_d == ERROR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         word_cnt_q    <= '0;
         tmo_cnt_q     <= '0;
         word_ready_q  <= 1'b0;
         load_params_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_cnt_q    <= word_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         word_ready_q  <= word_ready_d;
         load_params_q <= load_params_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
      end
   end

   assign word_ready  = word_ready_q;
   assign load_params = load_params_q;
   assign param_data  = sh_bit;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;

endmodule : rsnn_param_serializer

// File: tb/tb_rsnn_param_serializer.sv
// ----------------------------------------------------------------------------
// tb_rsnn_param_serializer
//
// Directed bench for rsnn_param_serializer in its default build. Two
// instances share the source and RSNN-side inputs: dut uses the default
// 24-word image, dut1 is built with NUM_WORDS=1. Inputs change on the
// falling edge and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rsnn_param_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, start1;
   logic [7:0] word_data;
   logic       word_valid;
   logic       data_written;
   logic       end_writing;

   logic word_ready, param_data, load_params, busy, done, error;
   logic word_ready1, param_data1, load_params1, busy1, done1, error1;

   int errors = 0;
   int checks = 0;
   int hs_cnt = 0;

   always #5 clk = ~clk;

   rsnn_param_serializer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .param_data   (param_data),
      .load_params  (load_params),
      .data_written (data_written),
      .end_writing  (end_writing),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   rsnn_param_serializer #(.NUM_WORDS(1)) dut1 (
      .clk          (clk),
      .reset        (reset),
      .start        (start1),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready1),
      .param_data   (param_data1),
      .load_params  (load_params1),
      .data_written (data_written),
      .end_writing  (end_writing),
      .busy         (busy1),
      .done         (done1),
      .error        (error1)
   );

   // Handshakes accepted by the 24-word instance.
   always @(posedge clk) begin
      if (word_valid && word_ready) hs_cnt <= hs_cnt + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   // Start pulse; returns on the falling edge where WAIT_WORD is visible.
   task automatic pulse_start(input bit sel);
      if (sel) start1 = 1'b1;
      else     start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start1 = 1'b0;
   endtask

   // Ack pulse after d falling edges; returns one edge after the pulse.
   task automatic ack_after(input int d);
      repeat (d) @(negedge clk);
      data_written = 1'b1;
      @(negedge clk);
      data_written = 1'b0;
   endtask

   // Offer one word, wait (bounded) for acceptance, then collect the framed
   // bits. Returns on the first falling edge with load_params low.
   task automatic push_word(input bit sel, input logic [7:0] w, input bit stray,
                            output logic [7:0] bits, output int nlp, output bit ok);
      ok = 1'b0;
      bits = '0;
      nlp = 0;
      word_data = w;
      word_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if ((sel ? word_ready1 : word_ready) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      word_valid = 1'b0;
      word_data = '0;
      for (int k = 0; k < 12; k++) begin
         if ((sel ? load_params1 : load_params) !== 1'b1) break;
         bits = {bits[6:0], (sel ? param_data1 : param_data)};
         nlp++;
         start = stray && (k == 2);
         data_written = stray && (k == 2);
         @(negedge clk);
      end
      start = 1'b0;
      data_written = 1'b0;
   endtask

   // Full 24-word image with values base+i, acked 2 cycles after each word.
   task automatic run_image(input logic [7:0] base, input int stray_idx, input string tag);
      logic [7:0] bits;
      logic [7:0] exp;
      int nlp;
      bit ok;
      for (int i = 0; i < 24; i++) begin
         exp = base + 8'(i);
         push_word(1'b0, exp, (i == stray_idx), bits, nlp, ok);
         checks++;
         if (!ok || bits !== exp || nlp != 8) begin
            errors++;
            $display("FAIL %s word %0d: accepted=%0b bits=%h cycles=%0d, required accepted=1 bits=%h cycles=8",
                     tag, i, ok, bits, nlp, exp);
         end
         ack_after(2);
      end
      checks++;
      if ({busy, done, word_ready, error} !== 4'b1000) begin
         errors++;
         $display("FAIL %s finish_wait: busy/done/ready/error=%b, required 1000", tag,
                  {busy, done, word_ready, error});
      end
      repeat (3) @(negedge clk);
      end_writing = 1'b1;
      @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b10) begin
         errors++;
         $display("FAIL %s done_pulse: done/busy=%b, required 10", tag, {done, busy});
      end
      end_writing = 1'b0;
      @(negedge clk);
      checks++;
      if ({done, busy, error} !== 3'b000) begin
         errors++;
         $display("FAIL %s after_done: done/busy/error=%b, required 000", tag, {done, busy, error});
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({word_ready, param_data, load_params, busy, done, error} !== 6'b0) begin
         errors++;
         $display("FAIL reset_dut: outputs=%b, required 000000",
                  {word_ready, param_data, load_params, busy, done, error});
      end
      checks++;
      if ({word_ready1, param_data1, load_params1, busy1, done1, error1} !== 6'b0) begin
         errors++;
         $display("FAIL reset_dut1: outputs=%b, required 000000",
                  {word_ready1, param_data1, load_params1, busy1, done1, error1});
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({word_ready, load_params, busy, done, error} !== 5'b0) begin
         errors++;
         $display("FAIL idle_after_reset: outputs=%b, required 00000",
                  {word_ready, load_params, busy, done, error});
      end
   endtask

   task automatic test_single_word();
      logic [7:0] bits;
      int nlp;
      bit ok;
      pulse_start(1'b1);
      checks++;
      if ({busy1, word_ready1} !== 2'b11) begin
         errors++;
         $display("FAIL single_start: busy/ready=%b, required 11", {busy1, word_ready1});
      end
      push_word(1'b1, 8'hA5, 1'b0, bits, nlp, ok);
      checks++;
      if (!ok || bits !== 8'hA5 || nlp != 8) begin
         errors++;
         $display("FAIL single_bits: accepted=%0b bits=%h cycles=%0d, required 1 a5 8", ok, bits, nlp);
      end
      checks++;
      if ({load_params1, param_data1, busy1} !== 3'b001) begin
         errors++;
         $display("FAIL single_wait_ack: load/data/busy=%b, required 001",
                  {load_params1, param_data1, busy1});
      end
      data_written = 1'b1;
      end_writing = 1'b1;
      @(negedge clk);
      data_written = 1'b0;
      checks++;
      if ({done1, busy1} !== 2'b01) begin
         errors++;
         $display("FAIL single_finish: done/busy=%b, required 01", {done1, busy1});
      end
      @(negedge clk);
      checks++;
      if ({done1, busy1} !== 2'b10) begin
         errors++;
         $display("FAIL single_done: done/busy=%b, required 10", {done1, busy1});
      end
      end_writing = 1'b0;
      @(negedge clk);
      checks++;
      if ({done1, busy1, error1, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL single_after: done1/busy1/error1/busy=%b, required 0000",
                  {done1, busy1, error1, busy});
      end
   endtask

   task automatic test_full_image();
      int hs0;
      hs0 = hs_cnt;
      pulse_start(1'b0);
      run_image(8'h00, -1, "image");
      checks++;
      if (hs_cnt - hs0 != 24) begin
         errors++;
         $display("FAIL image_handshakes: got %0d, required 24", hs_cnt - hs0);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] bits;
      int nlp;
      bit ok;
      pulse_start(1'b0);
      push_word(1'b0, 8'h3C, 1'b0, bits, nlp, ok);
      checks++;
      if (!ok || bits !== 8'h3C || nlp != 8) begin
         errors++;
         $display("FAIL tmo_word: accepted=%0b bits=%h cycles=%0d, required 1 3c 8", ok, bits, nlp);
      end
      repeat (15) @(negedge clk);
      checks++;
      if ({error, busy} !== 2'b01) begin
         errors++;
         $display("FAIL tmo_cycle16: error/busy=%b, required 01", {error, busy});
      end
      @(negedge clk);
      checks++;
      if ({error, busy, word_ready, load_params} !== 4'b1000) begin
         errors++;
         $display("FAIL tmo_error: error/busy/ready/load=%b, required 1000",
                  {error, busy, word_ready, load_params});
      end
      ack_after(2);
      repeat (2) @(negedge clk);
      checks++;
      if ({error, busy} !== 2'b10) begin
         errors++;
         $display("FAIL tmo_sticky: error/busy=%b, required 10", {error, busy});
      end
      pulse_start(1'b0);
      checks++;
      if ({error, busy, word_ready} !== 3'b011) begin
         errors++;
         $display("FAIL tmo_restart: error/busy/ready=%b, required 011", {error, busy, word_ready});
      end
      push_word(1'b0, 8'h5A, 1'b0, bits, nlp, ok);
      checks++;
      if (!ok || bits !== 8'h5A || nlp != 8) begin
         errors++;
         $display("FAIL tmo_restart_word: accepted=%0b bits=%h cycles=%0d, required 1 5a 8", ok, bits, nlp);
      end
      // Acknowledge lands in the same cycle the timeout would fire.
      ack_after(15);
      checks++;
      if ({error, busy, word_ready} !== 3'b011) begin
         errors++;
         $display("FAIL ack_vs_timeout: error/busy/ready=%b, required 011", {error, busy, word_ready});
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_finish_timeout();
      logic [7:0] bits;
      int nlp;
      bit ok;
      pulse_start(1'b1);
      push_word(1'b1, 8'h42, 1'b0, bits, nlp, ok);
      checks++;
      if (!ok || bits !== 8'h42 || nlp != 8) begin
         errors++;
         $display("FAIL fin_word: accepted=%0b bits=%h cycles=%0d, required 1 42 8", ok, bits, nlp);
      end
      ack_after(0);
      repeat (15) @(negedge clk);
      checks++;
      if ({error1, busy1} !== 2'b01) begin
         errors++;
         $display("FAIL fin_cycle16: error/busy=%b, required 01", {error1, busy1});
      end
      @(negedge clk);
      checks++;
      if ({error1, busy1, done1} !== 3'b100) begin
         errors++;
         $display("FAIL fin_error: error/busy/done=%b, required 100", {error1, busy1, done1});
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_and_stray();
      logic [7:0] bits;
      int nlp;
      bit ok;
      pulse_start(1'b0);
      for (int i = 0; i < 3; i++) begin
         push_word(1'b0, 8'h10 + 8'(i), 1'b0, bits, nlp, ok);
         ack_after(2);
      end
      word_data = 8'hFF;
      word_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (word_ready === 1'b1) break;
         @(negedge clk);
      end
      @(negedge clk);
      word_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({load_params, param_data, busy} !== 3'b111) begin
         errors++;
         $display("FAIL mid_bit4: load/data/busy=%b, required 111", {load_params, param_data, busy});
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({load_params, busy, param_data, word_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset: load/busy/data/ready=%b, required 0000",
                  {load_params, busy, param_data, word_ready});
      end
      reset = 1'b0;
      @(negedge clk);
      pulse_start(1'b0);
      run_image(8'h80, 7, "restart");
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      start1 = 1'b0;
      word_data = '0;
      word_valid = 1'b0;
      data_written = 1'b0;
      end_writing = 1'b0;
      test_reset();
      test_single_word();
      test_full_image();
      test_timeout();
      test_finish_timeout();
      test_reset_mid_and_stray();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_rsnn_param_serializer

// File: doc/rsnn_param_serializer.md
Name: rsnn_param_serializer

Overview:
- Host-side transmitter for the RSNN serial parameter-load interface.
- Takes parallel parameter words from a host or ROM through a valid/ready handshake. Shifts each word MSB-first onto the RSNN `data_in` line with `load_params` framing.
- Waits for the RSNN `data_written` acknowledge after each word and for `end_writing` after the last word.
- Sits between the parameter source and RSNN_TopModule in the top-level integration.

Parameters:
- WORD_W, 8, bits per parameter word.
- NUM_WORDS, 24, words per full parameter image.
- ACK_TIMEOUT, 16, cycles to wait for `data_written` or `end_writing` before flagging an error.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a full image transfer.
- word_data  input  WORD_W  parallel parameter word.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  serializer accepts word_data this cycle.
- param_data  output  1  serial bit, drives RSNN data_in.
- load_params  output  1  framing, high while bits are shifted.
- data_written  input  1  RSNN per-word acknowledge (pulse).
- end_writing  input  1  RSNN indicates the parameter image is complete.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky timeout flag.

Behaviour:
- Reset values: word_ready=0, param_data=0, load_params=0, busy=0, done=0, error=0. FSM goes to IDLE and all counters clear.
- Reset mid-transfer aborts on the next edge; a partial word is discarded.
- All outputs are registered. The FSM has states IDLE, WAIT_WORD, SHIFT, WAIT_ACK, FINISH, ERROR.
- IDLE:
  - start=1 → WAIT_WORD; word_cnt=0; error cleared.
  - ERROR also exits on start with the same effect.
- WAIT_WORD:
  - word_ready=1.
  - On word_valid && word_ready: latch word into shreg, bit_cnt=0 → SHIFT.
- SHIFT:
  - load_params=1; param_data=shreg[WORD_W-1].
  - Shift left by 1 each cycle; bit_cnt increments.
  - After WORD_W cycles: load_params drops, → WAIT_ACK; tmo_cnt=0.
  - The first bit appears the cycle after the handshake; a word occupies exactly WORD_W consecutive load_params cycles.
- WAIT_ACK:
  - load_params=0; param_data=0; tmo_cnt increments.
  - On data_written: if word_cnt==NUM_WORDS-1 → FINISH (tmo_cnt=0), else word_cnt++ → WAIT_WORD.
  - If tmo_cnt reaches ACK_TIMEOUT-1 without data_written → ERROR.
  - If data_written and the timeout coincide, the acknowledge wins.
- FINISH:
  - On end_writing=1 → IDLE, with a done pulse for 1 cycle.
  - On timeout → ERROR.
  - end_writing is level-sensitive and may already be high on entry, giving a 1-cycle finish.
- ERROR: error=1 and busy=0, held until start or reset.
- busy=1 in WAIT_WORD, SHIFT, WAIT_ACK, FINISH.
- Ignored inputs:
  - start while busy.
  - data_written outside WAIT_ACK.
  - end_writing outside FINISH.
  - word_valid when word_ready=0; the source must hold the word.
- Counter widths: word_cnt is clog2(NUM_WORDS), bit_cnt is clog2(WORD_W+1), tmo_cnt is clog2(ACK_TIMEOUT). Counters never wrap past their terminal values.

Optional Feature:
- Macro RSNN_PARAM_PARITY_EN.
- When defined, each word is followed by one even-parity bit (XOR of the word) with load_params still high: WORD_W+1 shift cycles per word.
- When undefined, exactly WORD_W cycles per word and no parity logic.
- The ack/timeout behaviour is identical in both builds.

Decomposition:
- Package rsnn_ser_pkg holds:
  - the state enum (IDLE, WAIT_WORD, SHIFT, WAIT_ACK, FINISH, ERROR);
  - default WORD_W, NUM_WORDS, ACK_TIMEOUT constants;
  - a clog2-based width helper.
- One sub-module, rsnn_piso_shreg: loadable MSB-first shift register with bit counter, last-bit flag, and optional parity append.
- The FSM, handshake and timeout logic stay in the top module.

Test Plan:
- Single word (NUM_WORDS=1): start, present 8'hA5 → load_params high for 8 cycles with param_data sequence 1,0,1,0,0,1,0,1. Then data_written pulse and end_writing=1 → done pulses once; busy falls the same cycle.
- Full image of 24 words, 0x00..0x17, with the responder acking 2 cycles after each word → 24 framed bursts. done after end_writing; word_ready high exactly 24 times at handshake.
- Ack timeout: never assert data_written after the first word → error=1 after 16 cycles in WAIT_ACK; busy=0; the next start clears error and restarts from word 0.
- Reset at bit 4 of word 3 → next cycle load_params=0, busy=0. A new start retransmits from word 0 with no residual bits.
- Stray inputs: start and data_written pulsed during SHIFT → no effect on the bit sequence or word_cnt. data_written and the timeout coinciding → ack accepted, no error.
- With RSNN_PARAM_PARITY_EN: word 8'h07 → 9 load_params cycles, with final parity bit 1.
